// File: rtl/ex_stage_pkg.sv
// Shared encodings for the EX stage: MIPS opcode/funct values, instruction
// field helpers, exception codes and the multiply/divide state type.
package ex_stage_pkg;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_ADDI    = 6'h08;
   localparam logic [5:0] OP_ADDIU   = 6'h09;
   localparam logic [5:0] OP_SLTI    = 6'h0A;
   localparam logic [5:0] OP_SLTIU   = 6'h0B;
   localparam logic [5:0] OP_ANDI    = 6'h0C;
   localparam logic [5:0] OP_ORI     = 6'h0D;
   localparam logic [5:0] OP_XORI    = 6'h0E;
   localparam logic [5:0] OP_LUI     = 6'h0F;
   localparam logic [5:0] OP_LB      = 6'h20;
   localparam logic [5:0] OP_LH      = 6'h21;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_LBU     = 6'h24;
   localparam logic [5:0] OP_LHU     = 6'h25;
   localparam logic [5:0] OP_SB      = 6'h28;
   localparam logic [5:0] OP_SH      = 6'h29;
   localparam logic [5:0] OP_SW      = 6'h2B;

   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_SRL   = 6'h02;
   localparam logic [5:0] FN_SRA   = 6'h03;
   localparam logic [5:0] FN_SLLV  = 6'h04;
   localparam logic [5:0] FN_SRLV  = 6'h06;
   localparam logic [5:0] FN_SRAV  = 6'h07;
   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MTHI  = 6'h11;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MTLO  = 6'h13;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_DIVU  = 6'h1B;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_XOR   = 6'h26;
   localparam logic [5:0] FN_NOR   = 6'h27;
   localparam logic [5:0] FN_SLT   = 6'h2A;
   localparam logic [5:0] FN_SLTU  = 6'h2B;

   localparam logic [4:0] EXC_NONE = 5'd0;
   localparam logic [4:0] EXC_OV   = 5'd12;

   localparam logic [3:0] MULT_CYCLES = 4'd5;
   localparam logic [3:0] DIV_CYCLES  = 4'd10;

   typedef enum logic {
      MDU_IDLE,
      MDU_BUSY
   } mduState_e;

   typedef struct packed {
      logic [31:0] instruc;
      logic [31:0] pc;
      logic [31:0] aluRe;
      logic [31:0] wtdm;
      logic [4:0]  wra;
      logic        bd;
      logic [4:0]  exc;
      logic        overflow;
   } emReg_t;

   function automatic logic [5:0] opcodeOf(input logic [31:0] instr);
      return instr[31:26];
   endfunction

   function automatic logic [5:0] functOf(input logic [31:0] instr);
      return instr[5:0];
   endfunction

   function automatic logic [4:0] shamtOf(input logic [31:0] instr);
      return instr[10:6];
   endfunction

   // Two's-complement overflow of s = a + b; subtraction passes ~b.
   function automatic logic addOverflow(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] s);
      return (a[31] == b[31]) && (s[31] != a[31]);
   endfunction

endpackage

// File: rtl/ex_stage_mdu.sv
// Multiply/divide unit: operands are captured at start, HI/LO are updated
// when the fixed busy period expires; mthi/mtlo write HI/LO while idle.
module mdu
   import ex_stage_pkg::*;
(
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        intReq_i,
   input  logic        startMult_i,
   input  logic        startDiv_i,
   input  logic        signed_i,
   input  logic        mthi_i,
   input  logic        mtlo_i,
   input  logic [31:0] rs_i,
   input  logic [31:0] rt_i,
   output logic        busy_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   mduState_e          state_q, state_d;
   logic [3:0]         count_q, count_d;
   logic [31:0]        hi_q, hi_d, lo_q, lo_d;
   logic [31:0]        resHi_q, resHi_d, resLo_q, resLo_d;
   logic               divZero_q, divZero_d;

   logic signed [32:0] opA, opB, divisor;
   logic [63:0]        product;
   logic [31:0]        quotient, remainder;
   logic               rtZero;

   // A 33-bit extension lets one signed datapath serve both signed and
   // unsigned forms, and keeps -2^31 / -1 well defined.
   assign opA       = {signed_i & rs_i[31], rs_i};
   assign opB       = {signed_i & rt_i[31], rt_i};
   assign rtZero    = (rt_i == 32'd0);
   assign divisor   = rtZero ? 33'sd1 : opB;
   assign product   = 64'(opA) * 64'(opB);
   assign quotient  = 32'(opA / divisor);
   assign remainder = 32'(opA % divisor);

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      resHi_d   = resHi_q;
      resLo_d   = resLo_q;
      divZero_d = divZero_q;
      case (state_q)
         MDU_IDLE: begin
            if (!intReq_i) begin
               if (startMult_i) begin
                  state_d   = MDU_BUSY;
                  count_d   = MULT_CYCLES;
                  resHi_d   = product[63:32];
                  resLo_d   = product[31:0];
                  divZero_d = 1'b0;
               end else if (startDiv_i) begin
                  state_d   = MDU_BUSY;
                  count_d   = DIV_CYCLES;
                  resHi_d   = remainder;
                  resLo_d   = quotient;
                  divZero_d = rtZero;
               end else begin
                  if (mthi_i) hi_d = rs_i;
                  if (mtlo_i) lo_d = rs_i;
               end
            end
         end
         MDU_BUSY: begin
            count_d = count_q - 4'd1;
            if (count_q == 4'd1) begin
               state_d = MDU_IDLE;
               if (!divZero_q) begin
                  hi_d = resHi_q;
                  lo_d = resLo_q;
               end
            end
         end
         default: state_d = MDU_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= MDU_IDLE;
         count_q   <= 4'd0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         resHi_q   <= 32'd0;
         resLo_q   <= 32'd0;
         divZero_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         resHi_q   <= resHi_d;
         resLo_q   <= resLo_d;
         divZero_q <= divZero_d;
      end
   end

   assign busy_o = (state_q == MDU_BUSY);
   assign hi_o   = hi_q;
   assign lo_o   = lo_q;

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ALU and address generation, overflow detection,
// the EX/MEM pipeline register and the multiply/divide unit.
module ex_stage
   import ex_stage_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        IntReq,
   input  logic [31:0] E_instruc,
   input  logic [31:0] E_PC,
   input  logic [31:0] E_RS,
   input  logic [31:0] E_RT,
   input  logic [31:0] E_EXT,
   input  logic [4:0]  E_WRA,
   input  logic        E_BD,
   input  logic [4:0]  DE_Exc,
   output logic        E_Busy,
   output logic [31:0] E_AluRe,
   output logic [31:0] EM_instruc,
   output logic [31:0] EM_PC,
   output logic [31:0] EM_AluRe,
   output logic [31:0] EM_WTDM,
   output logic [4:0]  EM_WRA,
   output logic        EM_BD,
   output logic [4:0]  EM_Exc,
   output logic        EM_overflow
);

   logic [5:0]  opcode, funct;
   logic [4:0]  shamt;
   logic [31:0] hi, lo;
   logic [31:0] addRR, subRR, addRI, aluRes;
   logic        arithOv, memOv, startMult, startDiv, mduSigned;
   logic        doMthi, doMtlo, mduBusy;
   emReg_t      emReg_d, emReg_q;

   assign opcode = opcodeOf(E_instruc);
   assign funct  = functOf(E_instruc);
   assign shamt  = shamtOf(E_instruc);
   assign addRR  = E_RS + E_RT;
   assign subRR  = E_RS - E_RT;
   assign addRI  = E_RS + E_EXT;

   always_comb begin
      aluRes    = 32'd0;
      arithOv   = 1'b0;
      memOv     = 1'b0;
      startMult = 1'b0;
      startDiv  = 1'b0;
      mduSigned = 1'b0;
      doMthi    = 1'b0;
      doMtlo    = 1'b0;
      case (opcode)
         OP_SPECIAL: begin
            case (funct)
               FN_SLL:   aluRes = E_RT << shamt;
               FN_SRL:   aluRes = E_RT >> shamt;
               FN_SRA:   aluRes = $signed(E_RT) >>> shamt;
               FN_SLLV:  aluRes = E_RT << E_RS[4:0];
               FN_SRLV:  aluRes = E_RT >> E_RS[4:0];
               FN_SRAV:  aluRes = $signed(E_RT) >>> E_RS[4:0];
               FN_MFHI:  aluRes = hi;
               FN_MFLO:  aluRes = lo;
               FN_MTHI:  doMthi = 1'b1;
               FN_MTLO:  doMtlo = 1'b1;
               FN_MULT:  begin startMult = 1'b1; mduSigned = 1'b1; end
               FN_MULTU: startMult = 1'b1;
               FN_DIV:   begin startDiv = 1'b1; mduSigned = 1'b1; end
               FN_DIVU:  startDiv = 1'b1;
               FN_ADD:   begin aluRes = addRR; arithOv = addOverflow(E_RS, E_RT, addRR); end
               FN_ADDU:  aluRes = addRR;
               FN_SUB:   begin aluRes = subRR; arithOv = addOverflow(E_RS, ~E_RT, subRR); end
               FN_SUBU:  aluRes = subRR;
               FN_AND:   aluRes = E_RS & E_RT;
               FN_OR:    aluRes = E_RS | E_RT;
               FN_XOR:   aluRes = E_RS ^ E_RT;
               FN_NOR:   aluRes = ~(E_RS | E_RT);
               FN_SLT:   aluRes = {31'd0, $signed(E_RS) < $signed(E_RT)};
               FN_SLTU:  aluRes = {31'd0, E_RS < E_RT};
               default:  ;
            endcase
         end
         OP_ADDI:  begin aluRes = addRI; arithOv = addOverflow(E_RS, E_EXT, addRI); end
         OP_ADDIU: aluRes = addRI;
         OP_SLTI:  aluRes = {31'd0, $signed(E_RS) < $signed(E_EXT)};
         OP_SLTIU: aluRes = {31'd0, E_RS < E_EXT};
         OP_ANDI:  aluRes = E_RS & E_EXT;
         OP_ORI:   aluRes = E_RS | E_EXT;
         OP_XORI:  aluRes = E_RS ^ E_EXT;
         OP_LUI:   aluRes = {E_instruc[15:0], 16'd0};
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: begin
            aluRes = addRI;
            memOv  = addOverflow(E_RS, E_EXT, addRI);
         end
         default: ;
      endcase
   end

   // An interrupt squashes the instruction; an earlier exception code wins over Ov.
   always_comb begin
      emReg_d = '0;
      if (!IntReq) begin
         emReg_d.instruc  = E_instruc;
         emReg_d.pc       = E_PC;
         emReg_d.aluRe    = aluRes;
         emReg_d.wtdm     = E_RT;
         emReg_d.wra      = arithOv ? 5'd0 : E_WRA;
         emReg_d.bd       = E_BD;
         emReg_d.exc      = (DE_Exc != EXC_NONE) ? DE_Exc : (arithOv ? EXC_OV : EXC_NONE);
         emReg_d.overflow = memOv;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         emReg_q <= '0;
      end else begin
         emReg_q <= emReg_d;
      end
   end

   mdu u_mdu (
      .clk_i       (clk),
      .reset_i     (reset),
      .intReq_i    (IntReq),
      .startMult_i (startMult),
      .startDiv_i  (startDiv),
      .signed_i    (mduSigned),
      .mthi_i      (doMthi),
      .mtlo_i      (doMtlo),
      .rs_i        (E_RS),
      .rt_i        (E_RT),
      .busy_o      (mduBusy),
      .hi_o        (hi),
      .lo_o        (lo)
   );

   assign E_Busy      = mduBusy | startMult | startDiv;
   assign E_AluRe     = aluRes;
   assign EM_instruc  = emReg_q.instruc;
   assign EM_PC       = emReg_q.pc;
   assign EM_AluRe    = emReg_q.aluRe;
   assign EM_WTDM     = emReg_q.wtdm;
   assign EM_WRA      = emReg_q.wra;
   assign EM_BD       = emReg_q.bd;
   assign EM_Exc      = emReg_q.exc;
   assign EM_overflow = emReg_q.overflow;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: a cycle-level reference model predicts each
// cycle's combinational and registered outputs; a monitor compares them.
module tb_ex_stage;

   typedef enum int {
      K_ADDU, K_SUBU, K_ADD, K_SUB, K_AND, K_OR, K_XOR, K_NOR, K_SLT, K_SLTU,
      K_SLL, K_SRL, K_SRA, K_SLLV, K_SRLV, K_SRAV, K_LUI, K_ADDI, K_ADDIU,
      K_ANDI, K_ORI, K_XORI, K_SLTI, K_SLTIU, K_LW, K_LB, K_SW, K_SH, K_J,
      K_MFHI, K_MFLO, K_MTHI, K_MTLO, K_MULT, K_MULTU, K_DIV, K_DIVU
   } kind_e;

   typedef struct {
      logic [31:0] aluRe;
      bit          aluKnown;
      logic        busy;
      logic [31:0] instruc;
      logic [31:0] pc;
      logic [31:0] emAlu;
      bit          emAluKnown;
      logic [31:0] wtdm;
      logic [4:0]  wra;
      logic        bd;
      logic [4:0]  exc;
      logic        memOv;
   } exp_t;

   localparam longint MAXS = (64'sd1 <<< 31) - 64'sd1;
   localparam longint MINS = -(64'sd1 <<< 31);

   logic        clk = 1'b0;
   logic        reset, IntReq, E_BD, E_Busy, EM_BD, EM_overflow;
   logic [31:0] E_instruc, E_PC, E_RS, E_RT, E_EXT, E_AluRe;
   logic [31:0] EM_instruc, EM_PC, EM_AluRe, EM_WTDM;
   logic [4:0]  E_WRA, DE_Exc, EM_WRA, EM_Exc;

   exp_t        expQ[$];
   int          testsRun = 0;
   int          testsFailed = 0;
   int          cycle = 0;
   int          busyUntil = -1;
   logic [31:0] mHi = 32'd0, mLo = 32'd0, pHi = 32'd0, pLo = 32'd0;
   bit          pWrite = 1'b0;

   always #5 clk = ~clk;

   ex_stage dut (
      .clk(clk), .reset(reset), .IntReq(IntReq), .E_instruc(E_instruc), .E_PC(E_PC),
      .E_RS(E_RS), .E_RT(E_RT), .E_EXT(E_EXT), .E_WRA(E_WRA), .E_BD(E_BD), .DE_Exc(DE_Exc),
      .E_Busy(E_Busy), .E_AluRe(E_AluRe), .EM_instruc(EM_instruc), .EM_PC(EM_PC),
      .EM_AluRe(EM_AluRe), .EM_WTDM(EM_WTDM), .EM_WRA(EM_WRA), .EM_BD(EM_BD),
      .EM_Exc(EM_Exc), .EM_overflow(EM_overflow)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s at t=%0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
      end
   endtask

   function automatic logic [31:0] encode(input kind_e k, input logic [15:0] imm);
      logic [5:0] op, fn;
      logic [4:0] rsF, rtF, rdF, sh;
      rsF = 5'($urandom); rtF = 5'($urandom); rdF = 5'($urandom); sh = 5'($urandom);
      op = 6'h00; fn = 6'h00;
      case (k)
         K_SLL: fn = 6'h00;   K_SRL: fn = 6'h02;   K_SRA: fn = 6'h03;
         K_SLLV: fn = 6'h04;  K_SRLV: fn = 6'h06;  K_SRAV: fn = 6'h07;
         K_MFHI: fn = 6'h10;  K_MTHI: fn = 6'h11;  K_MFLO: fn = 6'h12;
         K_MTLO: fn = 6'h13;  K_MULT: fn = 6'h18;  K_MULTU: fn = 6'h19;
         K_DIV: fn = 6'h1A;   K_DIVU: fn = 6'h1B;  K_ADD: fn = 6'h20;
         K_ADDU: fn = 6'h21;  K_SUB: fn = 6'h22;   K_SUBU: fn = 6'h23;
         K_AND: fn = 6'h24;   K_OR: fn = 6'h25;    K_XOR: fn = 6'h26;
         K_NOR: fn = 6'h27;   K_SLT: fn = 6'h2A;   K_SLTU: fn = 6'h2B;
         K_ADDI: op = 6'h08;  K_ADDIU: op = 6'h09; K_SLTI: op = 6'h0A;
         K_SLTIU: op = 6'h0B; K_ANDI: op = 6'h0C;  K_ORI: op = 6'h0D;
         K_XORI: op = 6'h0E;  K_LUI: op = 6'h0F;   K_LB: op = 6'h20;
         K_LW: op = 6'h23;    K_SH: op = 6'h29;    K_SW: op = 6'h2B;
         K_J: op = 6'h02;
         default: ;
      endcase
      if (op == 6'h00) return {op, rsF, rtF, rdF, sh, fn};
      return {op, rsF, rtF, imm};
   endfunction

   // Reference results from plain 64-bit arithmetic on the architectural rules.
   function automatic void refAlu(input kind_e k, input logic [31:0] rs, input logic [31:0] rt,
                                  input logic [31:0] ext, input logic [4:0] sh,
                                  input logic [15:0] imm, output logic [31:0] res,
                                  output bit known, output bit ov, output bit memOv);
      longint sa, st, se, wide;
      longint unsigned ua, ut, ue;
      sa = longint'($signed(rs)); st = longint'($signed(rt)); se = longint'($signed(ext));
      ua = {32'd0, rs}; ut = {32'd0, rt}; ue = {32'd0, ext};
      res = 32'd0; known = 1'b1; ov = 1'b0; memOv = 1'b0; wide = 0;
      case (k)
         K_ADD, K_ADDU:   begin wide = sa + st; ov = (k == K_ADD) && (wide > MAXS || wide < MINS); res = wide[31:0]; end
         K_SUB, K_SUBU:   begin wide = sa - st; ov = (k == K_SUB) && (wide > MAXS || wide < MINS); res = wide[31:0]; end
         K_ADDI, K_ADDIU: begin wide = sa + se; ov = (k == K_ADDI) && (wide > MAXS || wide < MINS); res = wide[31:0]; end
         K_LW, K_LB, K_SW, K_SH: begin wide = sa + se; memOv = (wide > MAXS || wide < MINS); res = wide[31:0]; end
         K_AND:   res = rs & rt;
         K_OR:    res = rs | rt;
         K_XOR:   res = rs ^ rt;
         K_NOR:   res = ~(rs | rt);
         K_ANDI:  res = rs & ext;
         K_ORI:   res = rs | ext;
         K_XORI:  res = rs ^ ext;
         K_SLT:   res = (sa < st) ? 32'd1 : 32'd0;
         K_SLTU:  res = (ua < ut) ? 32'd1 : 32'd0;
         K_SLTI:  res = (sa < se) ? 32'd1 : 32'd0;
         K_SLTIU: res = (ua < ue) ? 32'd1 : 32'd0;
         K_SLL:   begin wide = st * (64'sd1 <<< sh); res = wide[31:0]; end
         K_SRL:   begin wide = longint'(ut / (64'd1 << sh)); res = wide[31:0]; end
         K_SRA:   begin wide = st >>> sh; res = wide[31:0]; end
         K_SLLV:  begin wide = st * (64'sd1 <<< rs[4:0]); res = wide[31:0]; end
         K_SRLV:  begin wide = longint'(ut / (64'd1 << rs[4:0])); res = wide[31:0]; end
         K_SRAV:  begin wide = st >>> rs[4:0]; res = wide[31:0]; end
         K_LUI:   res = {imm, 16'd0};
         K_MFHI:  res = mHi;
         K_MFLO:  res = mLo;
         default: known = 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] randVal();
      case ($urandom_range(0, 7))
         0: return 32'h7FFFFFFF;
         1: return 32'h80000000;
         2: return 32'hFFFFFFFF;
         3: return 32'd0;
         4: return 32'($urandom_range(0, 20)) - 32'd10;
         default: return $urandom;
      endcase
   endfunction

   task automatic applyStimulus(input kind_e k, input logic [31:0] rs, input logic [31:0] rt,
                                input logic [15:0] imm, input logic [4:0] deExc,
                                input bit irq, input bit rst);
      exp_t        e;
      logic [31:0] instr, ext, res;
      bit          known, ov, memOv, flush;
      longint      sa, st, sq, sr;
      longint unsigned up;
      @(posedge clk);
      #1;
      ext   = (k inside {K_ANDI, K_ORI, K_XORI}) ? {16'd0, imm} : {{16{imm[15]}}, imm};
      instr = encode(k, imm);
      reset = rst; IntReq = irq; E_instruc = instr; E_PC = $urandom; E_RS = rs; E_RT = rt;
      E_EXT = ext; E_WRA = 5'($urandom); E_BD = 1'($urandom); DE_Exc = deExc;

      refAlu(k, rs, rt, ext, instr[10:6], imm, res, known, ov, memOv);
      flush        = irq || rst;
      e.aluRe      = res;
      e.aluKnown   = known;
      e.busy       = (cycle <= busyUntil) || (k >= K_MULT);
      e.instruc    = flush ? 32'd0 : instr;
      e.pc         = flush ? 32'd0 : E_PC;
      e.emAlu      = flush ? 32'd0 : res;
      e.emAluKnown = flush || known;
      e.wtdm       = flush ? 32'd0 : rt;
      e.wra        = (flush || ov) ? 5'd0 : E_WRA;
      e.bd         = flush ? 1'b0 : E_BD;
      e.exc        = flush ? 5'd0 : (deExc != 5'd0) ? deExc : (ov ? 5'd12 : 5'd0);
      e.memOv      = flush ? 1'b0 : memOv;
      expQ.push_back(e);

      sa = longint'($signed(rs)); st = longint'($signed(rt));
      if (rst) begin
         mHi = 32'd0; mLo = 32'd0; busyUntil = -1; pWrite = 1'b0;
      end else begin
         if (cycle == busyUntil && pWrite) begin mHi = pHi; mLo = pLo; end
         if (!irq && cycle > busyUntil) begin
            case (k)
               K_MTHI: mHi = rs;
               K_MTLO: mLo = rs;
               K_MULT: begin sq = sa * st; {pHi, pLo} = sq; pWrite = 1'b1; busyUntil = cycle + 5; end
               K_MULTU: begin up = {32'd0, rs} * {32'd0, rt}; {pHi, pLo} = up; pWrite = 1'b1; busyUntil = cycle + 5; end
               K_DIV: begin
                  pWrite = (rt != 32'd0); busyUntil = cycle + 10;
                  if (pWrite) begin sq = sa / st; sr = sa % st; pLo = sq[31:0]; pHi = sr[31:0]; end
               end
               K_DIVU: begin
                  pWrite = (rt != 32'd0); busyUntil = cycle + 10;
                  if (pWrite) begin pLo = rs / rt; pHi = rs % rt; end
               end
               default: ;
            endcase
         end
      end
      cycle++;
   endtask

   task automatic runFiller(input int n);
      for (int i = 0; i < n; i++)
         applyStimulus(kind_e'($urandom_range(0, int'(K_J))), randVal(), randVal(),
                       16'($urandom), 5'd0, 1'b0, 1'b0);
   endtask

   // Monitor: combinational outputs in the issue cycle, EM_* one cycle later.
   initial begin : monitor
      exp_t cur, pend;
      bit   havePend;
      havePend = 1'b0;
      forever begin
         @(negedge clk);
         if (havePend) begin
            checkOutput("EM_instruc", EM_instruc, pend.instruc);
            checkOutput("EM_PC", EM_PC, pend.pc);
            if (pend.emAluKnown) checkOutput("EM_AluRe", EM_AluRe, pend.emAlu);
            checkOutput("EM_WTDM", EM_WTDM, pend.wtdm);
            checkOutput("EM_WRA", 32'(EM_WRA), 32'(pend.wra));
            checkOutput("EM_BD", 32'(EM_BD), 32'(pend.bd));
            checkOutput("EM_Exc", 32'(EM_Exc), 32'(pend.exc));
            checkOutput("EM_overflow", 32'(EM_overflow), 32'(pend.memOv));
         end
         havePend = 1'b0;
         if (expQ.size() > 0) begin
            cur = expQ.pop_front();
            if (cur.aluKnown) checkOutput("E_AluRe", E_AluRe, cur.aluRe);
            checkOutput("E_Busy", 32'(E_Busy), 32'(cur.busy));
            pend     = cur;
            havePend = 1'b1;
         end
      end
   end

   initial begin : driver
      kind_e k;
      reset = 1'b1; IntReq = 1'b0; E_instruc = 32'd0; E_PC = 32'd0; E_RS = 32'd0;
      E_RT = 32'd0; E_EXT = 32'd0; E_WRA = 5'd0; E_BD = 1'b0; DE_Exc = 5'd0;

      applyStimulus(K_ADDU, 32'd1, 32'd2, 16'd0, 5'd0, 1'b0, 1'b1);
      applyStimulus(K_ADDU, 32'd3, 32'd4, 16'd0, 5'd0, 1'b0, 1'b0);
      applyStimulus(K_ADD, 32'h7FFFFFFF, 32'd1, 16'd0, 5'd0, 1'b0, 1'b0);
      applyStimulus(K_ADDU, 32'h7FFFFFFF, 32'd1, 16'd0, 5'd0, 1'b0, 1'b0);
      applyStimulus(K_SUB, 32'h80000000, 32'd1, 16'd0, 5'd7, 1'b0, 1'b0);
      applyStimulus(K_MULT, 32'hFFFFFFFF, 32'd2, 16'd0, 5'd0, 1'b0, 1'b0);
      runFiller(5);
      applyStimulus(K_MFHI, 32'd0, 32'd0, 16'd0, 5'd0, 1'b0, 1'b0);
      applyStimulus(K_MFLO, 32'd0, 32'd0, 16'd0, 5'd0, 1'b0, 1'b0);
      applyStimulus(K_MULTU, 32'hFFFFFFFF, 32'd2, 16'd0, 5'd0, 1'b0, 1'b0);
      runFiller(5);
      applyStimulus(K_MFHI, 32'd0, 32'd0, 16'd0, 5'd0, 1'b0, 1'b0);
      applyStimulus(K_MFLO, 32'd0, 32'd0, 16'd0, 5'd0, 1'b0, 1'b0);
      applyStimulus(K_DIV, 32'hFFFFFFF9, 32'd2, 16'd0, 5'd0, 1'b0, 1'b0);
      runFiller(10);
      applyStimulus(K_MFHI, 32'd0, 32'd0, 16'd0, 5'd0, 1'b0, 1'b0);
      applyStimulus(K_MFLO, 32'd0, 32'd0, 16'd0, 5'd0, 1'b0, 1'b0);
      applyStimulus(K_DIVU, 32'd55, 32'd0, 16'd0, 5'd0, 1'b0, 1'b0);
      runFiller(10);
      applyStimulus(K_MFHI, 32'd0, 32'd0, 16'd0, 5'd0, 1'b0, 1'b0);
      applyStimulus(K_MFLO, 32'd0, 32'd0, 16'd0, 5'd0, 1'b0, 1'b0);
      applyStimulus(K_LW, 32'h7FFFFFFC, 32'd9, 16'd8, 5'd0, 1'b0, 1'b0);
      applyStimulus(K_MULT, 32'd5, 32'd7, 16'd0, 5'd0, 1'b1, 1'b0);
      applyStimulus(K_MFLO, 32'd0, 32'd0, 16'd0, 5'd0, 1'b0, 1'b0);
      applyStimulus(K_MTHI, 32'h1234, 32'd0, 16'd0, 5'd0, 1'b1, 1'b0);
      applyStimulus(K_MFHI, 32'd0, 32'd0, 16'd0, 5'd0, 1'b0, 1'b0);
      applyStimulus(K_DIV, 32'd100, 32'd7, 16'd0, 5'd0, 1'b0, 1'b0);
      runFiller(7);
      applyStimulus(K_ADDU, 32'd1, 32'd1, 16'd0, 5'd0, 1'b1, 1'b1);
      applyStimulus(K_MFHI, 32'd0, 32'd0, 16'd0, 5'd0, 1'b0, 1'b0);
      applyStimulus(K_MFLO, 32'd0, 32'd0, 16'd0, 5'd0, 1'b0, 1'b0);

      for (int i = 0; i < 600; i++) begin
         if (cycle <= busyUntil) k = kind_e'($urandom_range(0, int'(K_J)));
         else k = kind_e'($urandom_range(0, int'(K_DIVU)));
         applyStimulus(k, randVal(), randVal(), 16'($urandom),
                       ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0,
                       $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
      end

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL provide ports:
- clk  in  1  — sole clock; all state updates on rising edge.
- reset  in  1  — synchronous, active-high.
- IntReq  in  1  — exception/interrupt taken this cycle; flushes EX output register.
- E_instruc  in  32  — instruction in EX.
- E_PC  in  32  — its PC.
- E_RS  in  32  — forwarded rs value.
- E_RT  in  32  — forwarded rt value.
- E_EXT  in  32  — extended immediate.
- E_WRA  in  5  — destination register (0 = none).
- E_BD  in  1  — branch-delay-slot flag.
- DE_Exc  in  5  — exception code [6:2] carried from earlier stages.
- E_Busy  out  1  — MDU busy or starting; ID uses it to stall.
- E_AluRe  out  32  — combinational result, for forwarding.
- EM_instruc  out  32  — registered copy of E_instruc.
- EM_PC  out  32  — registered copy of E_PC.
- EM_AluRe  out  32  — registered result or effective address.
- EM_WTDM  out  32  — registered store data (E_RT).
- EM_WRA  out  5  — registered destination.
- EM_BD  out  1  — registered delay-slot flag.
- EM_Exc  out  5  — registered exception code [6:2].
- EM_overflow  out  1  — load/store address-add overflow.

Function
REQ-002 SHALL decode internally: addu, subu, add, sub, and, or, xor, nor, slt, sltu, sll, srl, sra, sllv, srlv, srav, lui, addi, addiu, andi, ori, xori, slti, sltiu, loads, stores, mult, multu, div, divu, mfhi, mflo, mthi, mtlo.
REQ-003 SHALL compute E_AluRe combinationally; mfhi/mflo return HI/LO, and loads/stores return E_RS+E_EXT (mod 2^32).
REQ-004 SHALL use shift amounts instr[10:6] for sll/srl/sra and E_RS[4:0] for the variable shifts; slt/slti compare signed, sltu/sltiu compare unsigned, both 32-bit.
REQ-005 SHALL raise signed overflow only for add/addi/sub; EM_Exc then gets Ov (12) unless DE_Exc≠0, which keeps priority.
REQ-006 SHALL set EM_overflow=1 when a load/store signed address add overflows; EM_Exc unchanged.
REQ-007 SHALL force EM_WRA=0 when add/addi/sub overflows.
REQ-008 SHALL, on any edge without reset/IntReq, latch all EM_* outputs; latency is 1 cycle.
REQ-009 SHALL implement MDU states IDLE and BUSY with a 4-bit counter.
- mult/multu in IDLE: load count=5 and go BUSY.
- div/divu in IDLE: load count=10 and go BUSY.
- BUSY: decrement count each cycle; at count==1 write HI/LO and return to IDLE.
- MDU visible latency: 5 cycles (mult), 10 cycles (div).
REQ-010 SHALL compute operands and results at start and hold them internally; E_RS/E_RT changes during BUSY have no effect.
REQ-011 SHALL produce mult {HI,LO}=64-bit product, and div LO=quotient, HI=remainder (signed: truncate toward zero, remainder takes dividend sign).
REQ-012 SHALL leave HI/LO unchanged on divide-by-zero, still spending 10 busy cycles.
REQ-013 SHALL assert E_Busy when state==BUSY or an MDU start instruction is in EX; an MDU op (including mfhi/mflo/mthi/mtlo) is never presented while E_Busy=1.
REQ-014 SHALL write mthi/mtlo to HI/LO at the edge ending their EX cycle, in IDLE only.
REQ-015 SHALL, when IntReq=1, zero all EM_* outputs, suppress an MDU start and mthi/mtlo in EX, and let an in-progress BUSY operation complete.

Reset
REQ-016 SHALL on reset zero every EM_* output, HI, LO, and the counter, and set state IDLE; E_Busy=0 in the cycle after.
REQ-017 SHALL abort an in-progress MDU operation on reset with HI/LO=0; reset overrides IntReq.

Structure
REQ-018 SHALL take opcode/funct constants, field macros (rs, rt, rd, shamt) and exception codes (Ov=12, AdEL=4, AdES=5) from shared macro.v.
REQ-019 SHALL place the MDU (IDLE/BUSY FSM, counter, HI, LO, mthi/mtlo) in sub-module mdu, instantiated once.

Verification
REQ-020 SHALL cover these directed scenarios:
- add with RS=0x7FFFFFFF, RT=1 -> EM_Exc=12, EM_WRA=0; addu same operands -> EM_AluRe=0x80000000, EM_Exc=0.
- mult RS=0xFFFFFFFF, RT=2 -> E_Busy high 5 cycles, then mfhi=0xFFFFFFFF and mflo=0xFFFFFFFE; multu same operands -> HI=1, LO=0xFFFFFFFE.
- div RS=-7, RT=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; div by 0 -> HI/LO unchanged.
- lw with RS=0x7FFFFFFC, EXT=8 -> EM_overflow=1, EM_AluRe=0x80000004.
- IntReq coincident with mult in EX -> EM_* all zero, E_Busy low next cycle, HI/LO unchanged.
- reset asserted at count 3 of div -> IDLE, HI=LO=0, all EM_* zero next cycle.
